// File: rtl/spectrum_bar_levels.sv
// spectrum_bar_levels: reduces FFT magnitude frames to per-column bar heights with peak-hold/decay and a registered read port
module spectrum_bar_levels #(
  parameter int COLS = 16,
  parameter int ROWS = 8,
  parameter int MAG_W = 16,
  parameter int BIN_W = 9,
  parameter int COL_SHIFT = 5,
  parameter int HOLD_FRAMES = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bin_valid,
  output logic             bin_ready,
  input  logic [BIN_W-1:0] bin_idx,
  input  logic [MAG_W-1:0] bin_mag,
  input  logic             bin_last,
  output logic             frame_ready,
  input  logic [3:0]       rd_x,
  output logic [3:0]       rd_height,
  output logic [3:0]       rd_peak,
  output logic             dropped
);
  localparam int CW = BIN_W - COL_SHIFT;
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [CW-1:0] LAST = CW'(COLS - 1);
  typedef enum logic {ACCUM, QUANT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] col;
  logic [MAG_W-1:0] acc [COLS];
  logic [3:0] h [COLS];
  logic [3:0] peak [COLS];
  logic [HOLD_W-1:0] hold [COLS];
  logic [3:0] new_h;
  int p;
  int lvl;
  assign col = bin_idx[BIN_W-1:COL_SHIFT];
  always_comb begin
    p = -1;
    for (int i = 0; i < MAG_W; i++) p = acc[cnt][i] ? i : p;
    lvl = p - (MAG_W - ROWS) + 1;
    new_h = lvl <= 0 ? 4'd0 : lvl >= ROWS ? 4'(ROWS) : 4'(lvl);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      bin_ready <= 1'b1;
      frame_ready <= 1'b0;
      dropped <= 1'b0;
      cnt <= '0;
      rd_height <= '0;
      rd_peak <= '0;
      for (int i = 0; i < COLS; i++) begin
        acc[i] <= '0;
        h[i] <= '0;
        peak[i] <= '0;
        hold[i] <= '0;
      end
    end else begin
      frame_ready <= 1'b0;
      rd_height <= h[rd_x];
      rd_peak <= peak[rd_x];
      if (bin_valid && !bin_ready) dropped <= 1'b1;
      if (state == ACCUM) begin
        if (bin_valid) begin
          if (bin_mag > acc[col]) acc[col] <= bin_mag;
          if (bin_last) begin
            state <= QUANT;
            bin_ready <= 1'b0;
            cnt <= '0;
          end
        end
      end else begin
        acc[cnt] <= '0;
        h[cnt] <= new_h;
        if (new_h >= peak[cnt]) begin
          peak[cnt] <= new_h;
          hold[cnt] <= HOLD_W'(HOLD_FRAMES);
        end else if (hold[cnt] != '0) hold[cnt] <= hold[cnt] - 1'b1;
        else peak[cnt] <= peak[cnt] - 1'b1;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          state <= ACCUM;
          bin_ready <= 1'b1;
          frame_ready <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spectrum_bar_levels.sv
// tb_spectrum_bar_levels: directed self-checking bench for spectrum_bar_levels
module tb_spectrum_bar_levels;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bin_valid = 1'b0;
  logic bin_ready;
  logic [8:0] bin_idx = '0;
  logic [15:0] bin_mag = '0;
  logic bin_last = 1'b0;
  logic frame_ready;
  logic [3:0] rd_x = '0;
  logic [3:0] rd_height;
  logic [3:0] rd_peak;
  logic dropped;
  int total = 0;
  int passed = 0;
  int busy;
  int pulses;
  int ep [16];
  spectrum_bar_levels dut (
    .clk(clk), .rst(rst), .bin_valid(bin_valid), .bin_ready(bin_ready),
    .bin_idx(bin_idx), .bin_mag(bin_mag), .bin_last(bin_last),
    .frame_ready(frame_ready), .rd_x(rd_x), .rd_height(rd_height),
    .rd_peak(rd_peak), .dropped(dropped)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bin_valid = 1'b0;
    bin_last = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic send(input int idx, input int mag, input bit last);
    @(negedge clk);
    bin_valid = 1'b1;
    bin_idx = 9'(idx);
    bin_mag = 16'(mag);
    bin_last = last;
    @(negedge clk);
    bin_valid = 1'b0;
    bin_last = 1'b0;
  endtask
  task automatic wait_frame(output int b);
    int n;
    b = 0;
    n = 0;
    while (!frame_ready && n < 200) begin
      if (!bin_ready) b++;
      @(negedge clk);
      n++;
    end
    chk("frame_seen", int'(frame_ready), 1);
  endtask
  task automatic rd(input int x, input int eh, input int epk);
    @(negedge clk);
    rd_x = 4'(x);
    @(negedge clk);
    chk($sformatf("height[%0d]", x), int'(rd_height), eh);
    chk($sformatf("peak[%0d]", x), int'(rd_peak), epk);
  endtask
  initial begin
    do_reset();
    chk("reset_ready", int'(bin_ready), 1);
    chk("reset_dropped", int'(dropped), 0);
    chk("reset_frame_ready", int'(frame_ready), 0);
    for (int x = 0; x < 16; x++) rd(x, 0, 0);
    send(0, 'h8000, 0);
    send(32, 'h0100, 0);
    send(511, 'h0400, 1);
    wait_frame(busy);
    chk("quant_cycles", busy, 16);
    chk("ready_back", int'(bin_ready), 1);
    @(negedge clk);
    chk("pulse_once", int'(frame_ready), 0);
    for (int x = 0; x < 16; x++) ep[x] = 0;
    ep[0] = 8;
    ep[1] = 1;
    ep[15] = 3;
    for (int x = 0; x < 16; x++) rd(x, ep[x], ep[x]);
    send(64, 'h0300, 0);
    send(70, 'h1000, 0);
    send(95, 'h0050, 1);
    wait_frame(busy);
    rd(2, 5, 5);
    rd(0, 0, 8);
    rd(1, 0, 1);
    send(480, 0, 1);
    wait_frame(busy);
    rd(2, 0, 5);
    do_reset();
    send(0, 'h8000, 1);
    wait_frame(busy);
    rd(0, 8, 8);
    for (int k = 1; k <= 8; k++) begin
      send(480, 0, 1);
      wait_frame(busy);
      rd(0, 0, k <= 6 ? 8 : 14 - k);
    end
    do_reset();
    send(32, 'h0100, 1);
    bin_valid = 1'b1;
    bin_idx = 9'd64;
    bin_mag = 16'hFFFF;
    bin_last = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
    bin_last = 1'b0;
    chk("dropped_set", int'(dropped), 1);
    wait_frame(busy);
    rd(1, 1, 1);
    rd(2, 0, 0);
    send(480, 0, 1);
    wait_frame(busy);
    rd(2, 0, 0);
    chk("dropped_sticky", int'(dropped), 1);
    do_reset();
    chk("dropped_cleared", int'(dropped), 0);
    send(0, 'h8000, 0);
    send(511, 'hFFFF, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midq_ready", int'(bin_ready), 1);
    chk("midq_frame_ready", int'(frame_ready), 0);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (frame_ready) pulses++;
    end
    chk("midq_no_pulse", pulses, 0);
    rd(0, 0, 0);
    rd(15, 0, 0);
    rd(4, 0, 0);
    send(32, 'h0200, 1);
    wait_frame(busy);
    rd(0, 0, 0);
    rd(1, 2, 2);
    rd(15, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
